mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_if.sv | 33 +++
 rtl/mem_port_arbiter.sv | 64 ++++++
 tb/tb_mem_port_arbiter.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch/data request ports and single-port memory bus shared by the arbiter
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              if_flush;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              halt;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  modport slave (
    input  if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, halt, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, halt, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between fetch and data ports, data first.
// Define MEM_ARB_STARVE_GUARD_EN to force a fetch after STARVE_MAX consecutive data wins.
module mem_port_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input logic               clk1,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ACC_IF, ACC_D, RESP_IF, RESP_D} state_t;
  state_t r_state;
  state_t w_next;
  state_t w_pick;
  logic   r_flushed;
  logic   w_arb;
  logic   w_force;
  logic   w_gi;
  logic   w_gd;
  logic   w_iv;
  logic   w_dv;
  // reads occupy the port for the following response cycle; stores free it at once
  always_comb begin
    w_arb  = r_state == IDLE || r_state == RESP_IF || r_state == RESP_D || (r_state == ACC_D && bus.d_we);
    w_pick = bus.halt ? IDLE : (bus.d_req && !w_force) ? ACC_D : bus.if_req ? ACC_IF : IDLE;
    w_next = w_arb ? w_pick : (r_state == ACC_IF) ? RESP_IF : RESP_D;
  end
  always_ff @(posedge clk1)
    if (rst) begin
      r_state   <= IDLE;
      r_flushed <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_flushed <= w_gi && bus.if_flush;
    end
  assign w_gi          = r_state == ACC_IF;
  assign w_gd          = r_state == ACC_D;
  assign w_iv          = r_state == RESP_IF && !r_flushed && !bus.if_flush;
  assign w_dv          = r_state == RESP_D;
  assign bus.if_gnt    = w_gi;
  assign bus.d_gnt     = w_gd;
  assign bus.mem_en    = w_gi || w_gd;
  assign bus.mem_we    = w_gd && bus.d_we;
  assign bus.mem_addr  = w_gi ? bus.if_addr : w_gd ? bus.d_addr : {ADDR_W{1'b0}};
  assign bus.mem_wdata = w_gd ? bus.d_wdata : {DATA_W{1'b0}};
  assign bus.if_rvalid = w_iv;
  assign bus.if_rdata  = w_iv ? bus.mem_rdata : {DATA_W{1'b0}};
  assign bus.d_rvalid  = w_dv;
  assign bus.d_rdata   = w_dv ? bus.mem_rdata : {DATA_W{1'b0}};
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);
  logic [CW-1:0] r_starve;
  assign w_force = bus.if_req && r_starve == SMAX;
  always_ff @(posedge clk1)
    if (rst || !bus.if_req || w_next == ACC_IF) r_starve <= '0;
    else if (w_next == ACC_D && r_starve != SMAX) r_starve <= r_starve + 1'b1;
`else
  assign w_force = 1'b0;
  if (STARVE_MAX < 1) begin : g_no_guard
  end
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus random traffic against a grant-level reference model
module tb_mem_port_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int SMAX = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  localparam logic [DW-1:0] ZD = '0;
  localparam logic [AW-1:0] ZA = '0;
  logic clk1 = 1'b0;
  logic rst = 1'b1;
  int vec = 0;
  int miss = 0;
  int eg = 0;
  int erv = 0;
  int scnt = 0;
  logic efl = 1'b0;
  logic [DW-1:0] erd = '0;
  logic [DW-1:0] mem [1024];
  logic [DW-1:0] ref_mem [1024];
  bit loaded = 1'b0;
  logic e_ifv;
  logic [111:0] obs, expv;
  always #5 clk1 = ~clk1;
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (.clk1(clk1), .rst(rst), .bus(bus));
  function automatic logic [DW-1:0] seed_word(input int i);
    return (i == 5) ? 32'hA5A5_0001 : (32'h3C00_0000 ^ (32'(i) * 32'h0001_9E37));
  endfunction
  always @(posedge clk1)
    if (!loaded) begin
      for (int i = 0; i < 1024; i++) mem[i] <= seed_word(i);
      loaded <= 1'b1;
    end else if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else bus.mem_rdata <= mem[bus.mem_addr];
    end
  assign obs = {bus.if_gnt, bus.if_rvalid, bus.if_rdata, bus.d_gnt, bus.d_rvalid, bus.d_rdata,
                bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata};
  always_comb begin
    e_ifv = erv == 1 && !efl && !bus.if_flush;
    expv  = {eg == 1, e_ifv, e_ifv ? erd : ZD, eg == 2, erv == 2, (erv == 2) ? erd : ZD,
             eg != 0, eg == 2 && bus.d_we, (eg == 1) ? bus.if_addr : (eg == 2) ? bus.d_addr : ZA,
             (eg == 2) ? bus.d_wdata : ZD};
  end
  task automatic drive(input logic ir, input logic [AW-1:0] ia, input logic fl, input logic dr,
                       input logic we, input logic [AW-1:0] da, input logic [DW-1:0] wd, input logic h);
    bus.if_req = ir; bus.if_addr = ia; bus.if_flush = fl; bus.d_req = dr;
    bus.d_we = we; bus.d_addr = da; bus.d_wdata = wd; bus.halt = h;
  endtask
  // eg: grant this cycle (0 none, 1 fetch, 2 data); erv: response this cycle (0 none, 1 fetch, 2 data)
  task automatic tick();
    int ng, nrv;
    logic frc;
    logic [DW-1:0] nrd;
    nrv = (eg == 1) ? 1 : (eg == 2 && !bus.d_we) ? 2 : 0;
    nrd = (eg == 1) ? ref_mem[bus.if_addr] : ref_mem[bus.d_addr];
    if (eg == 2 && bus.d_we) ref_mem[bus.d_addr] = bus.d_wdata;
    frc = GUARD && bus.if_req && scnt == SMAX;
    ng = (nrv != 0 || bus.halt) ? 0 : (bus.d_req && !frc) ? 2 : bus.if_req ? 1 : 0;
    if (!bus.if_req || ng == 1) scnt = 0;
    else if (ng == 2 && scnt < SMAX) scnt++;
    if (rst) begin ng = 0; nrv = 0; scnt = 0; end
    efl = bus.if_flush;
    eg = ng; erv = nrv; erd = nrd;
  endtask
  task automatic test_reset();
    for (int c = 0; c < 4; c++) begin
      rst = c < 3;
      drive(c < 3, 10'd5, 1'b0, c < 3, 1'b0, 10'd9, ZD, 1'b0);
      @(negedge clk1);
      vec++; if (obs !== expv) begin miss++; $display("FAIL reset c%0d got %h want %h", c, obs, expv); end
      vec++; if (obs !== 112'd0) begin miss++; $display("FAIL reset_zero c%0d got %h want 0", c, obs); end
      tick(); @(posedge clk1); #1;
    end
  endtask
  task automatic test_single_fetch();
    for (int c = 0; c < 4; c++) begin
      drive(c < 2, 10'd5, 1'b0, 1'b0, 1'b0, ZA, ZD, 1'b0);
      @(negedge clk1);
      vec++; if (obs !== expv) begin miss++; $display("FAIL fetch c%0d got %h want %h", c, obs, expv); end
      if (c == 1) begin vec++; if (bus.if_gnt !== 1'b1) begin miss++; $display("FAIL fetch_gnt got %b want 1", bus.if_gnt); end end
      if (c == 2) begin vec++; if ({bus.if_rvalid, bus.if_rdata} !== {1'b1, 32'hA5A5_0001}) begin miss++; $display("FAIL fetch_data got %b/%h want 1/a5a50001", bus.if_rvalid, bus.if_rdata); end end
      tick(); @(posedge clk1); #1;
    end
  endtask
  task automatic test_priority();
    for (int c = 0; c < 6; c++) begin
      drive(c < 4, 10'd3, 1'b0, c < 2, 1'b0, 10'd9, ZD, 1'b0);
      @(negedge clk1);
      vec++; if (obs !== expv) begin miss++; $display("FAIL prio c%0d got %h want %h", c, obs, expv); end
      if (c == 1) begin vec++; if ({bus.d_gnt, bus.if_gnt} !== 2'b10) begin miss++; $display("FAIL prio_dgnt got %b%b want 10", bus.d_gnt, bus.if_gnt); end end
      if (c == 2) begin vec++; if ({bus.d_rvalid, bus.d_rdata} !== {1'b1, seed_word(9)}) begin miss++; $display("FAIL prio_drdata got %b/%h want 1/%h", bus.d_rvalid, bus.d_rdata, seed_word(9)); end end
      if (c == 3) begin vec++; if (bus.if_gnt !== 1'b1) begin miss++; $display("FAIL prio_ifgnt got %b want 1", bus.if_gnt); end end
      tick(); @(posedge clk1); #1;
    end
  endtask
  task automatic test_flush();
    for (int c = 0; c < 7; c++) begin
      drive(c < 2 || c == 3 || c == 4, (c < 2) ? 10'd7 : 10'd5, c == 2, 1'b0, 1'b0, ZA, ZD, 1'b0);
      @(negedge clk1);
      vec++; if (obs !== expv) begin miss++; $display("FAIL flush c%0d got %h want %h", c, obs, expv); end
      if (c == 2) begin vec++; if (bus.if_rvalid !== 1'b0) begin miss++; $display("FAIL flush_drop got %b want 0", bus.if_rvalid); end end
      if (c == 3) begin vec++; if (obs !== 112'd0) begin miss++; $display("FAIL flush_idle got %h want 0", obs); end end
      if (c == 5) begin vec++; if ({bus.if_rvalid, bus.if_rdata} !== {1'b1, seed_word(5)}) begin miss++; $display("FAIL flush_next got %b/%h want 1/%h", bus.if_rvalid, bus.if_rdata, seed_word(5)); end end
      tick(); @(posedge clk1); #1;
    end
  endtask
  task automatic test_starve();
    logic seen = 1'b0;
    int nd = 0;
    int want = GUARD ? SMAX : 11;
    for (int c = 0; c < 12; c++) begin
      drive(!seen, 10'd20, 1'b0, 1'b1, 1'b1, AW'($urandom_range(16, 1023)), $urandom, 1'b0);
      @(negedge clk1);
      vec++; if (obs !== expv) begin miss++; $display("FAIL starve c%0d got %h want %h", c, obs, expv); end
      if (bus.if_gnt && !seen) seen = 1'b1;
      else if (bus.d_gnt && !seen) nd++;
      tick(); @(posedge clk1); #1;
    end
    vec++; if (seen !== GUARD || nd != want) begin miss++; $display("FAIL starve_count got seen=%b dgnt=%0d want seen=%b dgnt=%0d", seen, nd, GUARD, want); end
    for (int c = 0; c < 4; c++) begin
      drive(!seen, 10'd20, 1'b0, 1'b0, 1'b0, ZA, ZD, 1'b0);
      @(negedge clk1);
      vec++; if (obs !== expv) begin miss++; $display("FAIL starve_tail c%0d got %h want %h", c, obs, expv); end
      if (bus.if_gnt) seen = 1'b1;
      tick(); @(posedge clk1); #1;
    end
    vec++; if (seen !== 1'b1) begin miss++; $display("FAIL starve_release got %b want 1", seen); end
  endtask
  task automatic test_reset_mid();
    for (int c = 0; c < 6; c++) begin
      rst = c == 1;
      drive(c == 2 || c == 3, 10'd5, 1'b0, c < 2, 1'b0, 10'd9, ZD, 1'b0);
      @(negedge clk1);
      vec++; if (obs !== expv) begin miss++; $display("FAIL rstmid c%0d got %h want %h", c, obs, expv); end
      if (c == 1) begin vec++; if (bus.d_gnt !== 1'b1) begin miss++; $display("FAIL rstmid_gnt got %b want 1", bus.d_gnt); end end
      if (c == 2) begin vec++; if (obs !== 112'd0) begin miss++; $display("FAIL rstmid_zero got %h want 0", obs); end end
      if (c == 3) begin vec++; if (bus.d_rvalid !== 1'b0) begin miss++; $display("FAIL rstmid_norv got %b want 0", bus.d_rvalid); end end
      tick(); @(posedge clk1); #1;
    end
  endtask
  task automatic test_halt();
    for (int c = 0; c < 9; c++) begin
      drive(c < 5, 10'd5, 1'b0, c < 7, 1'b0, 10'd9, ZD, c < 5);
      @(negedge clk1);
      vec++; if (obs !== expv) begin miss++; $display("FAIL halt c%0d got %h want %h", c, obs, expv); end
      if (c >= 1 && c <= 5) begin vec++; if ({bus.if_gnt, bus.d_gnt} !== 2'b00) begin miss++; $display("FAIL halt_block c%0d got %b%b want 00", c, bus.if_gnt, bus.d_gnt); end end
      if (c == 6) begin vec++; if (bus.d_gnt !== 1'b1) begin miss++; $display("FAIL halt_resume got %b want 1", bus.d_gnt); end end
      tick(); @(posedge clk1); #1;
    end
  endtask
  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      rst = $urandom_range(0, 63) == 0;
      drive($urandom_range(0, 2) != 0, AW'($urandom_range(0, 31)), $urandom_range(0, 5) == 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, AW'($urandom_range(0, 31)),
            $urandom, $urandom_range(0, 7) == 0);
      @(negedge clk1);
      vec++; if (obs !== expv) begin miss++; $display("FAIL random c%0d got %h want %h", c, obs, expv); end
      tick(); @(posedge clk1); #1;
    end
    rst = 1'b0;
  endtask
  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = seed_word(i);
    drive(1'b0, ZA, 1'b0, 1'b0, 1'b0, ZA, ZD, 1'b0);
    rst = 1'b1;
    @(posedge clk1); #1;
    test_reset();
    test_single_fetch();
    test_priority();
    test_flush();
    test_starve();
    test_reset_mid();
    test_halt();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
